// File: rtl/serial_mag_comparator_if.sv
// rtl/serial_mag_comparator_if.sv - operand/result handshake bundle for serial_mag_comparator
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    localparam int NDIG = WIDTH / 2;
    localparam int DW   = $clog2(NDIG) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             busy;
    logic [DW-1:0]    digits;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy, digits
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy, digits
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - MSB-first serial magnitude comparator, optional SERIAL_CMP_EARLY_EXIT_EN
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_mag_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / 2;
    localparam int DW   = $clog2(NDIG) + 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [DW-1:0]    digits_q;

    logic [1:0]       dig_a;
    logic [1:0]       dig_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             slice_ne;
    logic             last_digit;

    // Shared 2-bit comparator slice on the digit selected by idx
    always_comb begin
        dig_a      = a_q[{idx, 1'b0} +: 2];
        dig_b      = b_q[{idx, 1'b0} +: 2];
        slice_gt   = dig_a > dig_b;
        slice_lt   = dig_a < dig_b;
        slice_ne   = slice_gt | slice_lt;
        last_digit = (idx == '0) || (EARLY_EXIT && slice_ne);
    end

    // Control FSM with sticky first-difference result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            digits_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        idx      <= IW'(NDIG - 1);
                        gt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        digits_q <= '0;
                        state    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    digits_q <= digits_q + DW'(1);
                    // Only the most significant differing digit decides the result
                    if (slice_ne && !gt_q && !lt_q) begin
                        gt_q <= slice_gt;
                        lt_q <= slice_lt;
                    end
                    if (last_digit) begin
                        eq_q  <= !(gt_q || lt_q || slice_ne);
                        state <= S_DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_COMPARE) || (state == S_DONE);
    assign bus.a_gt_b    = gt_q;
    assign bus.a_eq_b    = eq_q;
    assign bus.a_lt_b    = lt_q;
    assign bus.digits    = digits_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for serial_mag_comparator
module tb_serial_mag_comparator;
    localparam int WIDTH = 8;
    localparam int NDIG  = WIDTH / 2;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   d;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    bit   mon_en = 1'b1;
    bit   bp_rand = 1'b0;
    exp_t q[$];

    serial_mag_comparator_if #(.WIDTH(WIDTH)) sif ();

    serial_mag_comparator #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] x;
        int msb;
        e.gt = (a > b);
        e.eq = (a == b);
        e.lt = (a < b);
        e.acc = 0;
        if (a == b || !EARLY) begin
            e.d = NDIG;
        end else begin
            x = a ^ b;
            msb = 0;
            for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
            e.d = (NDIG - 1 - msb / 2) + 1;
        end
        return e;
    endfunction

    // Present one operand pair, holding in_valid until it is accepted
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int n;
        bit done;
        sif.in_valid = 1'b1;
        sif.a = a;
        sif.b = b;
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            if (sif.in_ready) begin
                e = model(a, b);
                e.acc = cyc + 1;
                q.push_back(e);
                @(posedge clk);
                @(negedge clk);
                sif.a = WIDTH'($urandom);
                sif.b = WIDTH'($urandom);
                done = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || sif.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    // Monitor: pop expected result on each new out_valid, then watch it stay frozen
    initial begin
        exp_t e;
        bit prev_ov = 1'b0;
        logic [5:0] held = '0;
        forever begin
            @(negedge clk);
            if (mon_en && sif.out_valid) begin
                if (!prev_ov) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("gt", int'(sif.a_gt_b), int'(e.gt));
                        chk("eq", int'(sif.a_eq_b), int'(e.eq));
                        chk("lt", int'(sif.a_lt_b), int'(e.lt));
                        chk("digits", int'(sif.digits), e.d);
                        chk("latency", cyc - e.acc, e.d);
                    end
                    held = {sif.a_gt_b, sif.a_eq_b, sif.a_lt_b, sif.digits};
                end else begin
                    chk("held_stable", int'({sif.a_gt_b, sif.a_eq_b, sif.a_lt_b, sif.digits}), int'(held));
                end
                chk("onehot", int'(sif.a_gt_b) + int'(sif.a_eq_b) + int'(sif.a_lt_b), 1);
                chk("in_ready_in_done", int'(sif.in_ready), 0);
                chk("busy_in_done", int'(sif.busy), 1);
            end
            prev_ov = sif.out_valid;
        end
    end

    // Random consumer back-pressure when enabled
    initial begin
        forever begin
            @(negedge clk);
            if (bp_rand) sif.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        sif.in_valid = 1'b0;
        sif.a = '0;
        sif.b = '0;
        sif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(sif.in_ready), 1);
        chk("rst_out_valid", int'(sif.out_valid), 0);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_flags", int'({sif.a_gt_b, sif.a_eq_b, sif.a_lt_b}), 0);
        chk("rst_digits", int'(sif.digits), 0);
        rst = 1'b0;

        send(8'hA5, 8'hA5);
        sif.in_valid = 1'b0;
        drain();
        send(8'h80, 8'h7F);
        sif.in_valid = 1'b0;
        drain();
        send(8'h12, 8'h13);
        sif.in_valid = 1'b0;
        drain();
        send(8'hFF, 8'hFF);
        send(8'h00, 8'hFF);
        send(8'h00, 8'h00);
        sif.in_valid = 1'b0;
        drain();

        // Back-pressure: result must stay frozen while out_ready is low
        sif.out_ready = 1'b0;
        send(8'h3C, 8'h4C);
        sif.in_valid = 1'b0;
        n = 0;
        while (!sif.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_valid", int'(sif.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(sif.out_valid), 1);
            chk("bp_lt", int'(sif.a_lt_b), 1);
            chk("bp_in_ready", int'(sif.in_ready), 0);
            @(negedge clk);
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", int'(sif.in_ready), 1);
        chk("bp_release_valid", int'(sif.out_valid), 0);
        drain();

        // Reset in the second COMPARE cycle discards the in-flight result
        mon_en = 1'b0;
        sif.in_valid = 1'b1;
        sif.a = 8'hFF;
        sif.b = 8'h00;
        @(negedge clk);
        sif.in_valid = 1'b0;
        chk("mid_busy", int'(sif.busy), 1);
        @(negedge clk);
`ifndef SERIAL_CMP_EARLY_EXIT_EN
        chk("mid_no_valid", int'(sif.out_valid), 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_idle", int'(sif.in_ready), 1);
        chk("mid_rst_valid", int'(sif.out_valid), 0);
        chk("mid_rst_busy", int'(sif.busy), 0);
        chk("mid_rst_flags", int'({sif.a_gt_b, sif.a_eq_b, sif.a_lt_b}), 0);
        chk("mid_rst_digits", int'(sif.digits), 0);
        mon_en = 1'b1;
        send(8'h01, 8'h02);
        sif.in_valid = 1'b0;
        drain();

        // Back-to-back with in_valid held high
        send(8'h10, 8'h20);
        send(8'h20, 8'h10);
        send(8'h55, 8'h55);
        sif.in_valid = 1'b0;
        drain();

        // Randomized operands with random consumer stalls
        bp_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            send(ra, rb);
            if ($urandom_range(0, 1) == 0) begin
                sif.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        sif.in_valid = 1'b0;
        bp_rand = 1'b0;
        sif.out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
